sign_extension: RTL and testbench
=================================

SIGN_EXTENSION -- requirements
Module: sign_extension

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, extended output width, required OUT_WIDTH >= IN_WIDTH+2.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_enable  input  1  capture enable; low holds all outputs.
REQ-006 SHALL have port i_modo  input  2  extension mode select.
REQ-007 SHALL have port i_entrada  input  IN_WIDTH  immediate to extend.
REQ-008 SHALL have port o_salida  output  OUT_WIDTH  extended result, registered.
REQ-009 SHALL have port o_valid  output  1  high for every cycle o_salida holds a result captured with i_enable=1 since reset.

Function
REQ-010 SHALL, for i_modo=00 (sign extend), produce {replicate(i_entrada[IN_WIDTH-1]), i_entrada}.
REQ-011 SHALL, for i_modo=01 (zero extend), produce {zeros, i_entrada}.
REQ-012 SHALL, for i_modo=10 (branch offset), produce the mode-00 result shifted left 2, LSBs zero, upper bits truncated to OUT_WIDTH.
REQ-013 SHALL, for i_modo=11, behave as defined by the LUI_EN configuration (REQ-021/REQ-022).
REQ-014 SHALL register the result: value computed from inputs sampled at edge N appears on o_salida after edge N, latency exactly 1 cycle.
REQ-015 SHALL, when i_enable=1 at a rising edge (reset low), load o_salida with the new result and set o_valid=1.
REQ-016 SHALL, when i_enable=0 at a rising edge, hold o_salida and o_valid unchanged, regardless of i_entrada or i_modo changes.
REQ-017 SHALL be purely combinational from sampled inputs to the result register; no multi-cycle state, no FSM.
REQ-018 SHALL treat i_entrada MSB as sign only in modes 00 and 10; bits above IN_WIDTH in mode 01 always zero.

Reset
REQ-019 SHALL, when i_reset=1 at a rising edge, set o_salida=0 and o_valid=0, overriding i_enable and any in-flight capture.
REQ-020 SHALL, on the first enabled edge after reset deassertion, capture normally with 1-cycle latency; reset asserted mid-stream discards the pending result.

Configuration
REQ-021 SHALL, with macro SIGN_EXTENSION_LUI_EN defined, implement i_modo=11 as load-upper: {i_entrada, zeros} placing i_entrada in bits [OUT_WIDTH-1:OUT_WIDTH-IN_WIDTH].
REQ-022 SHALL, without SIGN_EXTENSION_LUI_EN, treat i_modo=11 identically to i_modo=00 (sign extend); no LUI logic synthesized.

Verification
REQ-023 SHALL cover: reset, then i_enable=1, i_modo=00, i_entrada=0x0011 -> o_salida=0x00000011, o_valid=1 one cycle later.
REQ-024 SHALL cover: i_modo=00, i_entrada=0x8011 -> o_salida=0xFFFF8011; i_modo=01 same input -> 0x00008011.
REQ-025 SHALL cover: i_modo=10, i_entrada=0x8011 -> 0xFFFE0044; i_entrada=0x0011 -> 0x00000044.
REQ-026 SHALL cover: i_modo=11, i_entrada=0x8011 -> 0x80110000 with SIGN_EXTENSION_LUI_EN, 0xFFFF8011 without.
REQ-027 SHALL cover: i_enable=0 while i_entrada toggles 0x0011->0x8011 -> o_salida holds previous value; i_reset=1 mid-stream -> o_salida=0, o_valid=0 next edge.

Source files
------------

// File: rtl/sign_extension.sv
// Immediate extender: sign/zero/branch-offset extension of i_entrada, optional load-upper (SIGN_EXTENSION_LUI_EN).
// Latency: 1 cycle from an enabled rising edge to o_salida/o_valid.
// Backpressure: none; i_enable=0 freezes the output register and o_valid.
module sign_extension #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [1:0]           i_modo,
    input  logic [IN_WIDTH-1:0]  i_entrada,
    output logic [OUT_WIDTH-1:0] o_salida,
    output logic                 o_valid
);

    localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

    localparam logic [1:0] MODO_SEXT   = 2'b00;
    localparam logic [1:0] MODO_ZEXT   = 2'b01;
    localparam logic [1:0] MODO_BRANCH = 2'b10;

    logic [OUT_WIDTH-1:0] sext_dat;
    logic [OUT_WIDTH-1:0] zext_dat;
    logic [OUT_WIDTH-1:0] branch_dat;
    logic [OUT_WIDTH-1:0] result_dat;

    assign sext_dat   = {{EXT_W{i_entrada[IN_WIDTH-1]}}, i_entrada};
    assign zext_dat   = {{EXT_W{1'b0}}, i_entrada};
    // Word-aligned branch offset: the top two sign bits fall off the end.
    assign branch_dat = {sext_dat[OUT_WIDTH-3:0], 2'b00};

`ifdef SIGN_EXTENSION_LUI_EN
    logic [OUT_WIDTH-1:0] lui_dat;
    assign lui_dat = {i_entrada, {EXT_W{1'b0}}};
`endif

    always_comb begin
        result_dat = sext_dat;
        case (i_modo)
            MODO_SEXT:   result_dat = sext_dat;
            MODO_ZEXT:   result_dat = zext_dat;
            MODO_BRANCH: result_dat = branch_dat;
`ifdef SIGN_EXTENSION_LUI_EN
            default:     result_dat = lui_dat;
`else
            default:     result_dat = sext_dat;
`endif
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_salida <= '0;
            o_valid  <= 1'b0;
        end else if (i_enable) begin
            o_salida <= result_dat;
            o_valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_extension.sv
// Directed + random bench for sign_extension; expected results queued at drive time, checked one edge later.
module tb_sign_extension;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  modo;
    logic [15:0] din;
    logic [31:0] salida;
    logic        valid;

    int vectors;
    int miscompares;

    logic [32:0] exp_q[$];
    logic [31:0] mdl_salida;
    logic        mdl_valid;

    sign_extension #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_enable  (en),
        .i_modo    (modo),
        .i_entrada (din),
        .o_salida  (salida),
        .o_valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] d);
        int signed s;
        s = int'($signed(d));
        case (m)
            2'd0: model = s;
            2'd1: model = 32'(d);
            2'd2: model = s * 4;
`ifdef SIGN_EXTENSION_LUI_EN
            default: model = 32'(d) << 16;
`else
            default: model = s;
`endif
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic e,
                        input logic [1:0] m, input logic [15:0] d);
        logic [32:0] exp;
        @(negedge clk);
        rst  = r;
        en   = e;
        modo = m;
        din  = d;
        if (r) begin
            mdl_salida = '0;
            mdl_valid  = 1'b0;
        end else if (e) begin
            mdl_salida = model(m, d);
            mdl_valid  = 1'b1;
        end
        exp_q.push_back({mdl_valid, mdl_salida});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            vectors++;
            assert (salida === exp[31:0]) else begin
                miscompares++;
                $error("FAIL %s o_salida got %h expected %h", tag, salida, exp[31:0]);
            end
            vectors++;
            assert (valid === exp[32]) else begin
                miscompares++;
                $error("FAIL %s o_valid got %b expected %b", tag, valid, exp[32]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_salida  = '0;
        mdl_valid   = 1'b0;
        rst  = 1'b1;
        en   = 1'b0;
        modo = 2'b00;
        din  = 16'h0000;

        step("reset0",      1'b1, 1'b1, 2'b00, 16'h1234);
        step("reset1",      1'b1, 1'b0, 2'b00, 16'h0000);
        step("sext_pos",    1'b0, 1'b1, 2'b00, 16'h0011);
        step("sext_neg",    1'b0, 1'b1, 2'b00, 16'h8011);
        step("zext_neg",    1'b0, 1'b1, 2'b01, 16'h8011);
        step("branch_neg",  1'b0, 1'b1, 2'b10, 16'h8011);
        step("branch_pos",  1'b0, 1'b1, 2'b10, 16'h0011);
        step("mode11",      1'b0, 1'b1, 2'b11, 16'h8011);
        step("sext_pos2",   1'b0, 1'b1, 2'b00, 16'h0011);
        step("hold_a",      1'b0, 1'b0, 2'b00, 16'h8011);
        step("hold_b",      1'b0, 1'b0, 2'b01, 16'hFFFF);
        step("mid_reset",   1'b1, 1'b1, 2'b00, 16'h8011);
        step("hold_rst",    1'b0, 1'b0, 2'b00, 16'h8011);
        step("zext_ffff",   1'b0, 1'b1, 2'b01, 16'hFFFF);
        step("sext_7fff",   1'b0, 1'b1, 2'b00, 16'h7FFF);
        step("branch_ffff", 1'b0, 1'b1, 2'b10, 16'hFFFF);
        step("branch_7fff", 1'b0, 1'b1, 2'b10, 16'h7FFF);
        step("mode11_pos",  1'b0, 1'b1, 2'b11, 16'h0001);
        step("sext_zero",   1'b0, 1'b1, 2'b00, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            step("random",
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
